// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory request sequencer: FSM state encoding,
// default access window length and a constant-evaluable clog2.
package mem_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int DEF_ACCESS_CYCLES = 9;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mem_req_sequencer_if.sv
// Request, controller and response signals of the sequencer. The sequencer
// connects through the slave modport; the requester/bench uses the master modport.
interface mem_req_sequencer_if #(
  parameter int ADDR_W  = 3,
  parameter int WDATA_W = 3,
  parameter int RDATA_W = 16
);

  logic               req_valid;
  logic               req_ready;
  logic               req_wr;
  logic [ADDR_W-1:0]  req_addr;
  logic [WDATA_W-1:0] req_wdata;

  logic               ctl_en;
  logic               ctl_we;
  logic [ADDR_W-1:0]  ctl_addr;
  logic [WDATA_W-1:0] ctl_wdata;
  logic [RDATA_W-1:0] mem_rdata;

  logic               rsp_valid;
  logic [RDATA_W-1:0] rsp_data;
  logic               op_done;
  logic               busy;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata,
    input  req_ready, ctl_en, ctl_we, ctl_addr, ctl_wdata,
    input  rsp_valid, rsp_data, op_done, busy
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_rdata,
    output req_ready, ctl_en, ctl_we, ctl_addr, ctl_wdata,
    output rsp_valid, rsp_data, op_done, busy
  );

endinterface

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO with asynchronous reset. Full/empty come from the
// registered occupancy count, so a same-cycle pop never frees a slot for a push.
module mem_req_fifo
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int              PTR_W    = clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // NOTE: storage is deliberately left out of reset; only pointers and count
  // define validity, and a reset-free array maps onto plain RAM/flop banks.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mem_req_sequencer.sv
// Sequencer FSM: pops one command at a time, pulses ctl_en once, holds WE/addr/data
// across the controller's fixed access window and returns read data at its end.
module mem_req_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W        = 3,
  parameter int WDATA_W       = 3,
  parameter int RDATA_W       = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES
) (
  input logic               clk,
  input logic               reset,
  mem_req_sequencer_if.slave bus
);

  localparam int             ENTRY_W  = 1 + ADDR_W + WDATA_W;
  localparam int             CNT_W    = clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  state_e             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ctl_en;
  logic               r_ctl_we;
  logic [ADDR_W-1:0]  r_ctl_addr;
  logic [WDATA_W-1:0] r_ctl_wdata;
  logic               r_rsp_valid;
  logic [RDATA_W-1:0] r_rsp_data;
  logic               r_op_done;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic               w_head_wr;
  logic [ADDR_W-1:0]  w_head_addr;
  logic [WDATA_W-1:0] w_head_wdata;

  assign w_push       = bus.req_valid && !w_full;
  assign w_pop        = (r_state == IDLE) && !w_empty;
  assign w_head_wr    = w_head[ENTRY_W-1];
  assign w_head_addr  = w_head[WDATA_W +: ADDR_W];
  assign w_head_wdata = w_head[WDATA_W-1:0];

  mem_req_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.req_wr, bus.req_addr, bus.req_wdata}),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign bus.req_ready = !w_full;
  assign bus.ctl_en    = r_ctl_en;
  assign bus.ctl_we    = r_ctl_we;
  assign bus.ctl_addr  = r_ctl_addr;
  assign bus.ctl_wdata = r_ctl_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.op_done   = r_op_done;
  assign bus.busy      = (r_state != IDLE) || !w_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ctl_en    <= 1'b0;
      r_ctl_we    <= 1'b0;
      r_ctl_addr  <= '0;
      r_ctl_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_op_done   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low here with non-blocking assignments, so
      // each state only states when a pulse fires and every output stays a flop.
      r_ctl_en    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_op_done   <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (!w_empty) begin
            r_ctl_en    <= 1'b1;
            r_ctl_we    <= w_head_wr;
            r_ctl_addr  <= w_head_addr;
            r_ctl_wdata <= w_head_wdata;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_W'(1);
          r_state <= WAIT;
        end
        WAIT: begin
          if (r_cnt == LAST_CNT) begin
            // Bus is sampled on the same edge the controller completes its window.
            r_op_done <= 1'b1;
            if (!r_ctl_we) begin
              r_rsp_valid <= 1'b1;
              r_rsp_data  <= bus.mem_rdata;
            end
            r_state <= FINISH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        FINISH: begin
          r_ctl_we <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Self-checking bench for mem_req_sequencer: directed vector table, multi-cycle
// corner sequences and random traffic against a transaction-timing reference model.
module tb_mem_req_sequencer;

  logic clk;
  logic reset;

  mem_req_sequencer_if #(.ADDR_W(3), .WDATA_W(3), .RDATA_W(16)) bus ();

  mem_req_sequencer #(
    .ADDR_W        (3),
    .WDATA_W       (3),
    .RDATA_W       (16),
    .FIFO_DEPTH    (4),
    .ACCESS_CYCLES (9)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       wr;
    bit [2:0] addr;
    bit [2:0] wdata;
    int       acc;
    int       iss;
  } cmd_t;

  typedef struct {
    bit        wr;
    bit [2:0]  addr;
    bit [2:0]  wdata;
    bit [15:0] mem;
    bit        e_we;
    bit [2:0]  e_addr;
    bit [2:0]  e_wdata;
    int        e_wehi;
    int        e_rv;
    int        e_done;
    bit [15:0] e_rsp;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  // Reference model: each accepted command issues at max(accept+2, prev_issue+11)
  // and occupies its issue cycle through issue+9.
  cmd_t        mq[$];
  int          last_iss;
  logic [15:0] ring [16];
  bit          model_on;
  bit          e_en, e_we, e_done, e_rv, e_busy, e_ready;
  logic [2:0]  e_addr, e_wdata;
  logic [15:0] e_rsp;

  bit          drv_valid, drv_wr;
  bit [2:0]    drv_addr, drv_wdata;
  bit [15:0]   drv_mem;
  bit          accepted;
  bit          last_ready;

  int          cap_en_cnt, cap_rv_cnt, cap_done_cnt, cap_we_hi, cap_busy_hi;
  bit          cap_we;
  bit [2:0]    cap_addr, cap_wdata;
  int          en_times[$];
  int          en_addrs[$];

  vec_t        tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_iss = -100;
    e_addr   = '0;
    e_wdata  = '0;
    e_rsp    = '0;
  endtask

  task automatic model_cycle();
    int occ;
    while (mq.size() > 0 && mq[0].iss + 9 < n) void'(mq.pop_front());
    e_en = 0; e_we = 0; e_done = 0; e_rv = 0; e_busy = 0; occ = 0;
    foreach (mq[i]) begin
      if (n == mq[i].iss) begin
        e_en    = 1;
        e_addr  = mq[i].addr;
        e_wdata = mq[i].wdata;
      end
      if (n >= mq[i].iss && n <= mq[i].iss + 9) begin
        e_we = mq[i].wr;
        if (n == mq[i].iss + 9) begin
          e_done = 1;
          if (!mq[i].wr) begin
            e_rv  = 1;
            e_rsp = ring[(mq[i].iss + 8) % 16];
          end
        end
      end
      if (n >= mq[i].acc + 1) e_busy = 1;
      if (n >= mq[i].acc + 1 && n <= mq[i].iss - 1) occ++;
    end
    e_ready = (occ < 4);
    check("ctl_en",    bus.ctl_en,    e_en);
    check("ctl_we",    bus.ctl_we,    e_we);
    check("ctl_addr",  bus.ctl_addr,  e_addr);
    check("ctl_wdata", bus.ctl_wdata, e_wdata);
    check("op_done",   bus.op_done,   e_done);
    check("rsp_valid", bus.rsp_valid, e_rv);
    check("rsp_data",  bus.rsp_data,  e_rsp);
    check("busy",      bus.busy,      e_busy);
    check("req_ready", bus.req_ready, e_ready);
  endtask

  task automatic clear_cap();
    cap_en_cnt = 0; cap_rv_cnt = 0; cap_done_cnt = 0; cap_we_hi = 0; cap_busy_hi = 0;
    cap_we = 0; cap_addr = 0; cap_wdata = 0;
    en_times.delete();
    en_addrs.delete();
  endtask

  // One cycle: sample and compare at the falling edge, then drive this cycle's inputs.
  task automatic tick();
    cmd_t c;
    @(negedge clk);
    n++;
    last_ready = bus.req_ready;
    if (model_on) model_cycle();
    if (bus.ctl_en) begin
      cap_en_cnt++;
      cap_we    = bus.ctl_we;
      cap_addr  = bus.ctl_addr;
      cap_wdata = bus.ctl_wdata;
      en_times.push_back(n);
      en_addrs.push_back(int'(bus.ctl_addr));
    end
    if (bus.ctl_we)    cap_we_hi++;
    if (bus.rsp_valid) cap_rv_cnt++;
    if (bus.op_done)   cap_done_cnt++;
    if (bus.busy)      cap_busy_hi++;
    accepted      = 0;
    bus.mem_rdata = drv_mem;
    ring[n % 16]  = drv_mem;
    bus.req_valid = drv_valid && model_on;
    bus.req_wr    = drv_wr;
    bus.req_addr  = drv_addr;
    bus.req_wdata = drv_wdata;
    if (drv_valid && model_on && e_ready) begin
      accepted = 1;
      c.wr     = drv_wr;
      c.addr   = drv_addr;
      c.wdata  = drv_wdata;
      c.acc    = n;
      c.iss    = (n + 2 > last_iss + 11) ? n + 2 : last_iss + 11;
      last_iss = c.iss;
      mq.push_back(c);
    end
  endtask

  task automatic set_cmd(input bit wr, input bit [2:0] addr, input bit [2:0] wdata);
    drv_valid = 1; drv_wr = wr; drv_addr = addr; drv_wdata = wdata;
  endtask

  task automatic run_cmd(input bit wr, input bit [2:0] addr, input bit [2:0] wdata,
                         input bit [15:0] mem);
    clear_cap();
    drv_mem = mem;
    set_cmd(wr, addr, wdata);
    tick();
    check("accept", accepted, 1);
    drv_valid = 0;
    repeat (12) tick();
  endtask

  task automatic drain(input string name);
    int k;
    drv_valid = 0;
    k = 0;
    while (bus.busy && k < 200) begin
      tick();
      k++;
    end
    check(name, bus.busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 3'd3, 3'd5, 16'h0000, 1'b1, 3'd3, 3'd5, 10, 0, 1, 16'h0000};
    tbl[1] = '{1'b0, 3'd3, 3'd2, 16'h0005, 1'b0, 3'd3, 3'd2, 0,  1, 1, 16'h0005};
    tbl[2] = '{1'b1, 3'd7, 3'd2, 16'h1234, 1'b1, 3'd7, 3'd2, 10, 0, 1, 16'h0005};
    tbl[3] = '{1'b0, 3'd0, 3'd0, 16'hbeef, 1'b0, 3'd0, 3'd0, 0,  1, 1, 16'hbeef};
    tbl[4] = '{1'b0, 3'd5, 3'd7, 16'h0000, 1'b0, 3'd5, 3'd7, 0,  1, 1, 16'h0000};
    tbl[5] = '{1'b1, 3'd1, 3'd7, 16'hffff, 1'b1, 3'd1, 3'd7, 10, 0, 1, 16'h0000};

    reset = 1'b1;
    model_on = 0;
    drv_valid = 0; drv_wr = 0; drv_addr = 0; drv_wdata = 0; drv_mem = 0;
    bus.req_valid = 0; bus.req_wr = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.mem_rdata = 0;
    model_reset();
    clear_cap();
    #2;
    check("rst_ctl_en",    bus.ctl_en,    0);
    check("rst_ctl_we",    bus.ctl_we,    0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data",  bus.rsp_data,  0);
    check("rst_busy",      bus.busy,      0);
    tick();
    tick();
    reset = 1'b0;
    model_on = 1;
    tick();

    // Isolated commands from the vector table.
    foreach (tbl[i]) begin
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].mem);
      check("tbl_en_pulses", cap_en_cnt,    1);
      check("tbl_we",        cap_we,        tbl[i].e_we);
      check("tbl_addr",      cap_addr,      tbl[i].e_addr);
      check("tbl_wdata",     cap_wdata,     tbl[i].e_wdata);
      check("tbl_we_cycles", cap_we_hi,     tbl[i].e_wehi);
      check("tbl_rsp_pulse", cap_rv_cnt,    tbl[i].e_rv);
      check("tbl_op_done",   cap_done_cnt,  tbl[i].e_done);
      check("tbl_rsp_data",  bus.rsp_data,  tbl[i].e_rsp);
    end

    // Write in flight, then five reads back-to-back: FIFO fills, fifth waits for a slot.
    begin
      int acc5;
      int k;
      clear_cap();
      drv_mem = 16'h0042;
      set_cmd(1'b1, 3'd4, 3'd6);
      tick();
      drv_valid = 0;
      repeat (4) tick();
      acc5 = -1;
      for (int j = 0; j < 5; j++) begin
        set_cmd(1'b0, 3'(j + 1), 3'(j));
        k = 0;
        tick();
        if (j == 4) check("ready_low_when_full", last_ready, 0);
        while (!accepted && k < 40) begin
          tick();
          k++;
        end
        check("b2b_accept", accepted, 1);
        if (j == 4) acc5 = n;
      end
      drain("b2b_drain");
      check("b2b_en_count", en_times.size(), 6);
      if (en_times.size() == 6) begin
        check("full_push_retry", acc5 - en_times[0], 11);
        for (int j = 1; j < 6; j++) begin
          check("b2b_spacing", en_times[j] - en_times[j-1], 11);
          check("b2b_order",   en_addrs[j], j);
        end
        check("b2b_first", en_addrs[0], 4);
      end
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      drv_valid = ($urandom_range(0, 3) == 0);
      drv_wr    = 1'($urandom);
      drv_addr  = 3'($urandom);
      drv_wdata = 3'($urandom);
      drv_mem   = 16'($urandom);
      tick();
    end
    drain("rand_drain");

    // Reset in the middle of a read's access window.
    drv_mem = 16'h7e7e;
    set_cmd(1'b0, 3'd6, 3'd1);
    tick();
    drv_valid = 0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    model_on = 0;
    #1;
    check("mid_rst_ctl_en",    bus.ctl_en,    0);
    check("mid_rst_ctl_addr",  bus.ctl_addr,  0);
    check("mid_rst_ctl_wdata", bus.ctl_wdata, 0);
    check("mid_rst_rsp_data",  bus.rsp_data,  0);
    check("mid_rst_op_done",   bus.op_done,   0);
    check("mid_rst_busy",      bus.busy,      0);
    clear_cap();
    repeat (3) tick();
    reset = 1'b0;
    model_reset();
    model_on = 1;
    repeat (10) tick();
    check("abandoned_rsp",  cap_rv_cnt,   0);
    check("abandoned_done", cap_done_cnt, 0);
    run_cmd(1'b0, 3'd2, 3'd0, 16'h0a5a);
    check("post_rst_rsp_pulse", cap_rv_cnt,   1);
    check("post_rst_rsp_data",  bus.rsp_data, 16'h0a5a);

    // Quiet period.
    clear_cap();
    repeat (50) tick();
    check("idle_en",   cap_en_cnt,  0);
    check("idle_we",   cap_we_hi,   0);
    check("idle_busy", cap_busy_hi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_sequencer.md
Name: mem_req_sequencer

Overview:
Request front-end that sits directly upstream of the async SRAM controller. It accepts read/write commands over a valid/ready handshake and buffers them in a small FIFO. It issues each command to the controller as a one-cycle enable pulse with stable WE/addr/data, then waits out the controller's fixed access window. Read data is sampled from the memory bus at the end of the window and returned as a one-cycle response.

Parameters:
ADDR_W, 3, width of request/controller address
WDATA_W, 3, width of write data driven to controller
RDATA_W, 16, width of memory data bus sampled on reads
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
ACCESS_CYCLES, 9, cycles from ctl_en pulse until read data valid / controller back in READY (1 input register + 1 READY exit + 7 access)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  command offered
req_ready  output  1  FIFO can accept (not full)
req_wr  input  1  1=write, 0=read
req_addr  input  ADDR_W  command address
req_wdata  input  WDATA_W  write data
ctl_en  output  1  enable pulse to controller (EN)
ctl_we  output  1  write select to controller (WE)
ctl_addr  output  ADDR_W  address to controller
ctl_wdata  output  WDATA_W  write data to controller
mem_rdata  input  RDATA_W  memory data bus (MemDB) as seen by controller
rsp_valid  output  1  one-cycle pulse, read data valid
rsp_data  output  RDATA_W  captured read data, held until next read capture
op_done  output  1  one-cycle pulse at end of every access (read or write)
busy  output  1  access in flight or FIFO non-empty

Behaviour:
- Reset (async, immediate): FIFO empty, state IDLE, counter 0; ctl_en=0, ctl_we=0, ctl_addr=0, ctl_wdata=0, rsp_valid=0, rsp_data=0, op_done=0, busy=0; req_ready=1 once reset deasserts.
- Push when req_valid && req_ready. req_ready = !full, computed from current occupancy only: a pop in the same cycle does not open a slot (no push-through when full).
- Pop from empty never occurs; FIFO pointers wrap modulo FIFO_DEPTH; count is log2(FIFO_DEPTH)+1 bits.
- FSM, registered outputs:
  - IDLE: if FIFO non-empty, pop head, load ctl_we/ctl_addr/ctl_wdata from it, go to ISSUE.
  - ISSUE (1 cycle): ctl_en=1; counter<=1; go to WAIT.
  - WAIT: ctl_en=0; ctl_we/addr/wdata held stable; counter increments each cycle; at counter==ACCESS_CYCLES-1 go to FINISH.
  - FINISH (1 cycle): op_done=1; if read, rsp_data<=mem_rdata and rsp_valid=1; then ctl_we<=0 and go to IDLE.
- Issue-to-issue spacing = ACCESS_CYCLES+2 cycles for back-to-back commands. ctl_en is never high on consecutive cycles. ctl_we is never high outside ISSUE..FINISH of a write, so the controller never drives the bus during a read.
- Push into an empty FIFO while IDLE: earliest ISSUE is 2 cycles after the push edge (FIFO write, then IDLE pop).
- Writes produce op_done only; rsp_valid and rsp_data are unchanged.
- busy = (state!=IDLE) || !empty.
- Reset mid-access: everything returns to reset values at once. The in-flight access is abandoned and no op_done or rsp_valid is emitted. The controller finishes its own window independently.

Decomposition:
- Package mem_seq_pkg: state encodings IDLE/ISSUE/WAIT/FINISH (2-bit), default ACCESS_CYCLES, counter width function clog2.
- Sub-module mem_req_fifo: parameterised sync FIFO with async reset, storing {wr, addr, wdata}. Outputs full/empty/head; push/pop inputs. The top-level holds only the FSM, counter and output registers.

Test Plan:
- Write addr=3, wdata=5: ctl_en high exactly 1 cycle; ctl_we=1, ctl_addr=3, ctl_wdata=5 stable for 10 cycles (ISSUE..FINISH); op_done at cycle 10 after ISSUE; no rsp_valid.
- Read addr=3 with mem_rdata model returning 16'h0005 at access end: rsp_valid single pulse with rsp_data=16'h0005; ctl_we=0 throughout; rsp_data holds after pulse.
- Push 5 commands back-to-back with FIFO_DEPTH=4: req_ready drops after 4th accepted (while first pending); all 5 eventually issue in order; ctl_en pulses exactly 11 cycles apart.
- FIFO full, ISSUE pop and req_valid in same cycle: push refused that cycle, accepted the next; no loss or duplication.
- Assert reset during WAIT of a read: outputs immediately zero, busy=0, no rsp_valid/op_done; a new read after reset completes normally.
- Idle with no requests for 50 cycles: ctl_en, ctl_we, busy stay 0.
